// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and vote helper for the configurable UART blocks.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
  localparam int OVERSAMPLE  = 16;
  localparam int SAMPLE_MID  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every CLK_FREQ/(BAUD_RATE*16) clocks.
// clear restarts the phase so the first tick lands a full period later.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int BAUD_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Divider counter with registered tick output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
      tick  <= 1'b0;
    end else if (clear) begin
      r_cnt <= {CNT_W{1'b0}};
      tick  <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= {CNT_W{1'b0}};
      tick  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling, 3-sample majority vote,
// per-word framing/parity/break/overrun status on a valid/ready output.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_en,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun_err
);

  localparam logic [3:0] SAMP_A    = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] SAMP_B    = 4'(SAMPLE_MID);
  localparam logic [3:0] SAMP_C    = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] SAMP_END  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_t            r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_prev;
  logic [3:0]           r_samp;
  logic [3:0]           r_idx;
  logic                 r_s_a;
  logic                 r_s_b;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop0;
  logic                 r_ferr;
  logic                 r_commit;

  logic w_tick;
  logic w_start;
  logic w_mid;
  logic w_end;
  logic w_maj;
  logic w_perr;
  logic w_brk;

  assign w_start = rx_en & (r_state == ST_IDLE) & r_rx_prev & ~r_sync2;
  assign w_mid   = w_tick & (r_samp == SAMP_C);
  assign w_end   = w_tick & (r_samp == SAMP_END);
  assign w_maj   = maj3(r_s_a, r_s_b, r_sync2);

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_start),
    .tick  (w_tick)
  );

  // Two-flop synchroniser plus delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Frame FSM: sample counter, vote capture, shift register and stop status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_samp    <= 4'd0;
      r_idx     <= 4'd0;
      r_s_a     <= 1'b1;
      r_s_b     <= 1'b1;
      r_shift   <= {DATA_BITS{1'b0}};
      r_par_bit <= 1'b0;
      r_stop0   <= 1'b1;
      r_ferr    <= 1'b0;
      r_commit  <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (!rx_en && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
      end else begin
        if (w_tick) begin
          r_samp <= r_samp + 4'd1;
          if (r_samp == SAMP_A) r_s_a <= r_sync2;
          if (r_samp == SAMP_B) r_s_b <= r_sync2;
        end
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_samp  <= 4'd0;
              r_idx   <= 4'd0;
              r_ferr  <= 1'b0;
              r_stop0 <= 1'b1;
              r_state <= ST_START;
            end
          end
          ST_START: begin
            if (w_mid && w_maj) begin
              r_state <= ST_IDLE;
            end else if (w_end) begin
              r_idx   <= 4'd0;
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (w_mid) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            if (w_end) begin
              if (r_idx == DATA_LAST) begin
                r_idx   <= 4'd0;
                r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                r_idx <= r_idx + 4'd1;
              end
            end
          end
          ST_PARITY: begin
            if (w_mid) r_par_bit <= w_maj;
            if (w_end) begin
              r_idx   <= 4'd0;
              r_state <= ST_STOP;
            end
          end
          ST_STOP: begin
            // Leaving at the last stop bit's mid-point leaves half a bit to resync.
            if (w_mid) begin
              if (!w_maj) r_ferr <= 1'b1;
              if (r_idx == 4'd0) r_stop0 <= w_maj;
              if (r_idx == STOP_LAST) begin
                r_commit <= 1'b1;
                r_state  <= ST_IDLE;
              end
            end else if (w_end) begin
              r_idx <= r_idx + 4'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Parity check against the configured sense.
  always_comb begin
    w_perr = 1'b0;
    case (PARITY)
      PARITY_ODD:  w_perr = ~(^r_shift ^ r_par_bit);
      PARITY_EVEN: w_perr = ^r_shift ^ r_par_bit;
      default:     w_perr = 1'b0;
    endcase
  end

  assign w_brk = (r_shift == {DATA_BITS{1'b0}}) & ((PARITY == PARITY_NONE) | ~r_par_bit) & ~r_stop0;

  // Output word register with valid/ready handshake and overrun tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid    <= 1'b0;
      rx_out      <= {DATA_BITS{1'b0}};
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (r_commit) begin
      rx_valid    <= 1'b1;
      rx_out      <= r_shift;
      frame_err   <= r_ferr;
      parity_err  <= w_perr;
      break_det   <= w_brk;
      overrun_err <= rx_valid & ~rx_ready;
    end else if (rx_valid && rx_ready) begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: 8N1, 8E1 and 7O2 receivers on separate lines,
// each received word compared with a frame-level model of the line bits.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 25_000;
  localparam int BIT_CLK   = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_DIV  = BIT_CLK / 16;

  typedef struct packed {
    logic [1:0] id;
    logic [8:0] d;
    logic       fe;
    logic       pe;
    logic       bk;
    logic       ov;
  } word_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_en;
  logic       rx_ready;
  logic [2:0] rx_line;
  wire  [2:0] v, fe, pe, bk, ov;
  wire  [7:0] out0, out1;
  wire  [6:0] out2;

  word_t cap_q[$];
  bit    mon_on;
  int    n_checks = 0;
  int    n_errors = 0;
  int    vcnt0 = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .rx(rx_line[0]), .rx_en(rx_en), .rx_ready(rx_ready), .rx_valid(v[0]), .rx_out(out0),
    .frame_err(fe[0]), .parity_err(pe[0]), .break_det(bk[0]), .overrun_err(ov[0]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .rx(rx_line[1]), .rx_en(rx_en), .rx_ready(rx_ready), .rx_valid(v[1]), .rx_out(out1),
    .frame_err(fe[1]), .parity_err(pe[1]), .break_det(bk[1]), .overrun_err(ov[1]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7), .PARITY(PARITY_ODD), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .reset(reset), .rx(rx_line[2]), .rx_en(rx_en), .rx_ready(rx_ready), .rx_valid(v[2]), .rx_out(out2),
    .frame_err(fe[2]), .parity_err(pe[2]), .break_det(bk[2]), .overrun_err(ov[2]));

  function automatic int db_of(input logic [1:0] id);
    return (id == 2'd2) ? 7 : 8;
  endfunction

  function automatic int pm_of(input logic [1:0] id);
    return (id == 2'd0) ? PARITY_NONE : (id == 2'd1) ? PARITY_EVEN : PARITY_ODD;
  endfunction

  function automatic int ns_of(input logic [1:0] id);
    return (id == 2'd2) ? 2 : 1;
  endfunction

  function automatic int nbits_of(input logic [1:0] id);
    return 1 + db_of(id) + ((pm_of(id) != PARITY_NONE) ? 1 : 0) + ns_of(id);
  endfunction

  function automatic logic [8:0] mask_of(input logic [1:0] id);
    return 9'((1 << db_of(id)) - 1);
  endfunction

  // Parity bit a well-behaved transmitter would send.
  function automatic logic good_par(input logic [1:0] id, input logic [8:0] data);
    int ones;
    ones = $countones(data & mask_of(id));
    if (pm_of(id) == PARITY_ODD) return (ones % 2 == 0);
    if (pm_of(id) == PARITY_EVEN) return (ones % 2 == 1);
    return 1'b0;
  endfunction

  function automatic logic [15:0] frame_of(input logic [1:0] id, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
    logic [15:0] f;
    int pos;
    f = 16'hFFFF;
    f[0] = 1'b0;
    pos = 1;
    for (int i = 0; i < db_of(id); i++) begin f[pos] = data[i]; pos++; end
    if (pm_of(id) != PARITY_NONE) begin f[pos] = pbit; pos++; end
    for (int i = 0; i < ns_of(id); i++) begin f[pos] = stops[i]; pos++; end
    return f;
  endfunction

  function automatic word_t model(input logic [1:0] id, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
    word_t w;
    int ones;
    w.id = id;
    w.d  = data & mask_of(id);
    ones = $countones(w.d) + (pbit ? 1 : 0);
    if (pm_of(id) == PARITY_ODD) w.pe = (ones % 2 == 0);
    else if (pm_of(id) == PARITY_EVEN) w.pe = (ones % 2 == 1);
    else w.pe = 1'b0;
    w.fe = !stops[0] || ((ns_of(id) == 2) && !stops[1]);
    w.bk = (w.d == 9'd0) && ((pm_of(id) == PARITY_NONE) || !pbit) && !stops[0];
    w.ov = 1'b0;
    return w;
  endfunction

  function automatic word_t snap(input logic [1:0] id);
    word_t w;
    w.id = id;
    case (id)
      2'd0:    w.d = {1'b0, out0};
      2'd1:    w.d = {1'b0, out1};
      default: w.d = {2'b00, out2};
    endcase
    w.fe = fe[id];
    w.pe = pe[id];
    w.bk = bk[id];
    w.ov = ov[id];
    return w;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every handshaken word.
  always @(negedge clk) begin
    if (v[0]) vcnt0 <= vcnt0 + 1;
    if (mon_on && rx_ready && !reset) begin
      if (v[0]) cap_q.push_back(snap(2'd0));
      if (v[1]) cap_q.push_back(snap(2'd1));
      if (v[2]) cap_q.push_back(snap(2'd2));
    end
  end

  task automatic expect_word(input string tag, input word_t exp);
    word_t got;
    check_val({tag, "_count"}, cap_q.size(), 1);
    if (cap_q.size() > 0) begin
      got = cap_q.pop_front();
      check_val({tag, "_id"}, 32'(got.id), 32'(exp.id));
      check_val({tag, "_data"}, 32'(got.d), 32'(exp.d));
      check_val({tag, "_frame_err"}, 32'(got.fe), 32'(exp.fe));
      check_val({tag, "_parity_err"}, 32'(got.pe), 32'(exp.pe));
      check_val({tag, "_break"}, 32'(got.bk), 32'(exp.bk));
      check_val({tag, "_overrun"}, 32'(got.ov), 32'(exp.ov));
    end
    cap_q.delete();
  endtask

  task automatic expect_none(input string tag);
    check_val({tag, "_count"}, cap_q.size(), 0);
    cap_q.delete();
  endtask

  task automatic drive_bits(input logic [1:0] id, input logic [15:0] bits, input int first, input int last);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      rx_line[id] = bits[i];
      repeat (BIT_CLK - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [1:0] id, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
    drive_bits(id, frame_of(id, data, pbit, stops), 0, nbits_of(id));
    @(negedge clk);
    rx_line[id] = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [1:0] id, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
    send_frame(id, data, pbit, stops);
    expect_word(tag, model(id, data, pbit, stops));
  endtask

  initial begin
    logic [15:0] f;
    logic [8:0]  data;
    logic        pbit;
    logic [1:0]  stops;
    logic [1:0]  id;
    int          vbefore;

    reset = 1'b1; rx_en = 1'b1; rx_ready = 1'b1; rx_line = 3'b111; mon_on = 1'b1;
    repeat (5) @(negedge clk);
    check_val("rst_valid", 32'(v), 32'd0);
    check_val("rst_out0", 32'(out0), 32'd0);
    check_val("rst_out2", 32'(out2), 32'd0);
    check_val("rst_flags", 32'({fe, pe, bk, ov}), 32'd0);
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    expect_none("idle");

    vbefore = vcnt0;
    run_frame("8n1_a5", 2'd0, 9'h0A5, 1'b0, 2'b11);
    check_val("8n1_a5_pulse", vcnt0 - vbefore, 1);

    run_frame("8e1_5a_badpar", 2'd1, 9'h05A, 1'b1, 2'b11);
    run_frame("8e1_5a_goodpar", 2'd1, 9'h05A, 1'b0, 2'b11);

    run_frame("8n1_stop0", 2'd0, 9'h03C, 1'b0, 2'b10);
    @(negedge clk); rx_line[0] = 1'b0;
    repeat (12 * BIT_CLK - 1) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    expect_word("8n1_break", model(2'd0, 9'h000, 1'b0, 2'b00));

    @(negedge clk); rx_line[0] = 1'b0;
    repeat (4 * BAUD_DIV - 1) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    expect_none("false_start");
    run_frame("8n1_81", 2'd0, 9'h081, 1'b0, 2'b11);

    mon_on = 1'b0; rx_ready = 1'b0;
    send_frame(2'd0, 9'h011, 1'b0, 2'b11);
    check_val("hold_valid", 32'(v[0]), 32'd1);
    check_val("hold_out", 32'(out0), 32'h11);
    check_val("hold_overrun", 32'(ov[0]), 32'd0);
    send_frame(2'd0, 9'h022, 1'b0, 2'b11);
    check_val("ovr_valid", 32'(v[0]), 32'd1);
    check_val("ovr_out", 32'(out0), 32'h22);
    check_val("ovr_overrun", 32'(ov[0]), 32'd1);
    check_val("ovr_frame_err", 32'(fe[0]), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check_val("ack_valid", 32'(v[0]), 32'd0);
    check_val("ack_overrun", 32'(ov[0]), 32'd0);

    send_frame(2'd0, 9'h05B, 1'b0, 2'b11);
    check_val("pre_rst_valid", 32'(v[0]), 32'd1);
    f = frame_of(2'd0, 9'h0C3, 1'b0, 2'b11);
    drive_bits(2'd0, f, 0, 4);
    @(negedge clk); rx_line[0] = f[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rx_line[0] = 1'b1;
    reset = 1'b1;
    #1;
    check_val("midrst_valid", 32'(v[0]), 32'd0);
    check_val("midrst_out", 32'(out0), 32'd0);
    check_val("midrst_overrun", 32'(ov[0]), 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0; rx_ready = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    cap_q.delete();
    mon_on = 1'b1;
    run_frame("after_rst_c3", 2'd0, 9'h0C3, 1'b0, 2'b11);

    run_frame("7o2_55", 2'd2, 9'h055, good_par(2'd2, 9'h055), 2'b11);
    run_frame("7o2_stop0", 2'd2, 9'h02A, good_par(2'd2, 9'h02A), 2'b10);

    rx_en = 1'b0;
    send_frame(2'd0, 9'h077, 1'b0, 2'b11);
    expect_none("disabled");
    rx_en = 1'b1;
    f = frame_of(2'd0, 9'h0E7, 1'b0, 2'b11);
    drive_bits(2'd0, f, 0, 4);
    @(negedge clk); rx_en = 1'b0;
    drive_bits(2'd0, f, 4, 10);
    @(negedge clk); rx_line[0] = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    rx_en = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    expect_none("abort");
    run_frame("after_abort", 2'd0, 9'h0E7, 1'b0, 2'b11);

    for (int k = 0; k < 24; k++) begin
      id    = 2'(k % 3);
      data  = 9'($urandom_range(0, 511));
      pbit  = good_par(id, data);
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      stops = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      run_frame($sformatf("rnd%0d", k), id, data, pbit, stops);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
